// File: rtl/rx_filter_pkg.sv
// rx_filter_pkg: shared types and constants for the RX destination-MAC filter.
//   state_t         - frame FSM state (IDLE / PASS / DROP)
//   BCAST_MAC       - the all-ones broadcast destination
//   MIN_FIRST_KEEP  - tkeep[5:0] pattern a first beat needs to hold a full DA
//   get_dst_mac()   - reorders the first six wire bytes into a 48-bit DA
package rx_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;
    localparam logic [5:0]  MIN_FIRST_KEEP = 6'h3F;

    // Byte 0 on the wire sits in [7:0] of the beat, but the configured MAC
    // keeps its first wire byte in [47:40]; swap so the two compare directly.
    function automatic logic [47:0] get_dst_mac(input logic [47:0] first_bytes);
        return {first_bytes[7:0],   first_bytes[15:8],  first_bytes[23:16],
                first_bytes[31:24], first_bytes[39:32], first_bytes[47:40]};
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-beat AXI-Stream output register.
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid             - a beat is offered for loading
//   in_ready             - register can take a beat this cycle
//   in_data/keep/last    - beat contents
//   out_valid/data/keep/last - registered beat towards downstream
//   out_ready            - downstream ready
// The beat loads when in_valid && in_ready; out_valid clears when the held
// beat is taken and nothing new loads. in_ready only looks at the register
// state, so there is no combinational path from in_valid to in_ready.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last,
    input  logic                  out_ready
);

    logic load;

    // Free when empty, or when the held beat leaves this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_mac_filter.sv
// rx_mac_filter: destination-MAC filter on the RX AXI-Stream path.
//   clk, rst_n          - clock, synchronous active-low reset
//   s_t*                - upstream AXI-Stream (valid/data/keep/last/ready)
//   m_t*                - downstream AXI-Stream through a one-beat register
//   cfg_mac_addr        - station MAC, [47:40] first on the wire
//   cfg_promisc         - accept every non-runt frame
//   cfg_bcast_en        - accept the broadcast destination
//   stat_clr            - one-cycle pulse clearing all counters
//   stat_*_cnt          - saturating accept / drop / runt frame counters
//   dbg_state           - current frame FSM state
//
// Handshake: a beat moves on either stream only on a rising clk edge where
// valid && ready are both high; valid, once raised, holds with stable
// data/keep/last until that edge, and ready may rise or fall at any time.
//
// The forward/drop decision is taken on the first beat of a frame with the
// cfg_* values of that cycle; the FSM then carries it to tlast, so cfg
// changes mid-frame only affect the next frame.
module rx_mac_filter
    import rx_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic [47:0]           cfg_mac_addr,
    input  logic                  cfg_promisc,
    input  logic                  cfg_bcast_en,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  stat_accept_cnt,
    output logic [CNT_WIDTH-1:0]  stat_drop_cnt,
    output logic [CNT_WIDTH-1:0]  stat_runt_cnt,
    output state_t                dbg_state
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t      state, state_next;
    logic        slice_ready;
    logic        accept;
    logic        fwd;
    logic        inc_accept, inc_drop, inc_runt;
    logic [47:0] dst_mac;
    logic        is_runt, is_match;

    assign dbg_state = state;

    // DROP never stalls upstream; otherwise ready follows the output
    // register. Held low through reset so nothing is taken then.
    assign s_tready = rst_n && ((state == DROP) || slice_ready);
    assign accept   = s_tvalid && s_tready;

    assign dst_mac  = get_dst_mac(s_tdata[47:0]);
    // A first beat that is also the last, or that lacks any of the six DA
    // bytes, cannot be a valid frame. This also means a matched first beat
    // always leads into PASS.
    assign is_runt  = s_tlast || (s_tkeep[5:0] != MIN_FIRST_KEEP);
    assign is_match = cfg_promisc
                   || (cfg_bcast_en && (dst_mac == BCAST_MAC))
                   || (dst_mac == cfg_mac_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fwd        = 1'b0;
        inc_accept = 1'b0;
        inc_drop   = 1'b0;
        inc_runt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_runt) begin
                        inc_runt = 1'b1;
                    end else if (is_match) begin
                        fwd        = 1'b1;
                        state_next = PASS;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (s_tlast) begin
                        inc_accept = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept && s_tlast) begin
                    inc_drop   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    axis_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fwd),
        .in_ready  (slice_ready),
        .in_data   (s_tdata),
        .in_keep   (s_tkeep),
        .in_last   (s_tlast),
        .out_valid (m_tvalid),
        .out_data  (m_tdata),
        .out_keep  (m_tkeep),
        .out_last  (m_tlast),
        .out_ready (m_tready)
    );

    // Counters stick at all-ones; a clear in the same cycle as an
    // increment takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_accept_cnt <= '0;
            stat_drop_cnt   <= '0;
            stat_runt_cnt   <= '0;
        end else begin
            if (inc_accept && (stat_accept_cnt != '1)) begin
                stat_accept_cnt <= stat_accept_cnt + CNT_ONE;
            end
            if (inc_drop && (stat_drop_cnt != '1)) begin
                stat_drop_cnt <= stat_drop_cnt + CNT_ONE;
            end
            if (inc_runt && (stat_runt_cnt != '1)) begin
                stat_runt_cnt <= stat_runt_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rx_mac_filter.sv
// tb_rx_mac_filter: bench for rx_mac_filter with 64-bit data and 4-bit
// counters, so saturation is reachable in a few frames.
module tb_rx_mac_filter;
  import rx_filter_pkg::*;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;
  localparam int CMAX = 15;
  localparam int K_ACC = 0;
  localparam int K_DROP = 1;
  localparam int K_RUNT = 2;
  localparam int F_LAT = 1;
  localparam int F_NOOUT = 2;
  localparam int F_CLR = 4;
  localparam int F_GAPS = 8;
  localparam int F_SCRAMBLE = 16;
  localparam logic [47:0] MAC_A = 48'h0200_0000_0001;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tready;
  logic [47:0]   cfg_mac_addr;
  logic          cfg_promisc;
  logic          cfg_bcast_en;
  logic          stat_clr;
  logic [CW-1:0] stat_accept_cnt;
  logic [CW-1:0] stat_drop_cnt;
  logic [CW-1:0] stat_runt_cnt;
  state_t        dbg_state;

  rx_mac_filter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tready(m_tready),
    .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
    .stat_clr(stat_clr),
    .stat_accept_cnt(stat_accept_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_runt_cnt(stat_runt_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW+KW:0] exp_q[$];
  int exp_acc = 0;
  int exp_drop = 0;
  int exp_runt = 0;
  int rdy_mode = 0;
  int cyc = 0;
  bit chk_ready_rule = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] mk_beat0(input logic [47:0] dst, input logic [15:0] hi);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 6; i++) b[8*i +: 8] = dst[47-8*i -: 8];
    b[63:48] = hi;
    return b;
  endfunction

  function automatic logic [47:0] dst_of(input logic [63:0] b);
    logic [47:0] d;
    for (int i = 0; i < 6; i++) d[47-8*i -: 8] = b[8*i +: 8];
    return d;
  endfunction

  function automatic int classify(input int n, input logic [63:0] b0, input logic [7:0] k0,
                                  input logic [47:0] mac, input bit promisc, input bit bcast);
    logic [47:0] d;
    d = dst_of(b0);
    if (n == 1 || k0[5:0] != 6'h3F) return K_RUNT;
    if (promisc || (bcast && d == 48'hFFFF_FFFF_FFFF) || d == mac) return K_ACC;
    return K_DROP;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_accept_cnt"}, stat_accept_cnt, exp_acc);
    check({tag, "_drop_cnt"}, stat_drop_cnt, exp_drop);
    check({tag, "_runt_cnt"}, stat_runt_cnt, exp_runt);
  endtask

  // ---------------- downstream ready driver ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_ready_rule) check("s_tready_rule", s_tready, !(m_tvalid && !m_tready));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %0h expected none", {m_tlast, m_tkeep, m_tdata});
        end else begin
          check("out_beat", {m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output int stalls);
    bit rdy;
    stalls = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    forever begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalls++;
      if (stalls > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got stall expected accept");
        break;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic send_frame(input int n, input logic [63:0] b0, input logic [7:0] k0,
                            input int kind, input int flags, input string tag);
    logic [63:0] da[8];
    logic [7:0]  ka[8];
    int stalls;
    da[0] = b0;
    ka[0] = k0;
    for (int i = 1; i < n; i++) begin
      da[i] = {$urandom, $urandom};
      ka[i] = 8'($urandom);
    end
    if (kind == K_ACC)
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), ka[i], da[i]});
    for (int i = 0; i < n; i++) begin
      if ((flags & F_CLR) != 0 && i == n - 1) stat_clr = 1'b1;
      send_beat(da[i], ka[i], (i == n - 1), stalls);
      stat_clr = 1'b0;
      if ((flags & F_LAT) != 0) begin
        check({tag, "_lat_valid"}, m_tvalid, 1'b1);
        check({tag, "_lat_beat"}, {m_tlast, m_tkeep, m_tdata}, {(i == n - 1), ka[i], da[i]});
      end
      if ((flags & F_NOOUT) != 0) begin
        check({tag, "_no_stall"}, stalls, 0);
        check({tag, "_no_out"}, m_tvalid, 1'b0);
      end
      if (i == 0 && (flags & F_SCRAMBLE) != 0) begin
        cfg_promisc = 1'($urandom_range(0, 1));
        cfg_mac_addr = {16'($urandom), $urandom};
      end
      if ((flags & F_GAPS) != 0 && i < n - 1) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if ((flags & F_CLR) != 0) begin
      exp_acc = 0;
      exp_drop = 0;
      exp_runt = 0;
    end else if (kind == K_ACC) exp_acc = sat_inc(exp_acc);
    else if (kind == K_DROP) exp_drop = sat_inc(exp_drop);
    else exp_runt = sat_inc(exp_runt);
    check_counters(tag);
  endtask

  task automatic set_cfg(input logic [47:0] mac, input bit promisc, input bit bcast);
    cfg_mac_addr = mac;
    cfg_promisc = promisc;
    cfg_bcast_en = bcast;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] b0;
    logic [7:0]  k0;
    int          n;
    logic [47:0] mac;
    bit          promisc;
    bit          bcast;
    int          kind;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main test ----------------
  initial begin
    int stalls;
    logic [63:0] b;
    logic [7:0] k;
    logic [47:0] d;
    int n;
    int kind;

    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    stat_clr = 1'b0;
    set_cfg(MAC_A, 1'b0, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_tready, 1'b0);
    @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_state", dbg_state, IDLE);
    check_counters("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table of single frames, always-ready sink
    vecs[0] = '{64'hBBAA_0100_0000_0002, 8'hFF, 3, MAC_A, 1'b0, 1'b0, K_ACC};
    vecs[1] = '{mk_beat0(48'h0200_0000_0002, 16'hBBAA), 8'hFF, 3, MAC_A, 1'b0, 1'b0, K_DROP};
    vecs[2] = '{mk_beat0(48'hFFFF_FFFF_FFFF, 16'h1234), 8'hFF, 3, MAC_A, 1'b0, 1'b0, K_DROP};
    vecs[3] = '{mk_beat0(48'hFFFF_FFFF_FFFF, 16'h1234), 8'hFF, 3, MAC_A, 1'b0, 1'b1, K_ACC};
    vecs[4] = '{mk_beat0(48'h0A0B_0C0D_0E0F, 16'h5555), 8'hFF, 2, MAC_A, 1'b1, 1'b0, K_ACC};
    vecs[5] = '{mk_beat0(MAC_A, 16'h0000), 8'hFF, 1, MAC_A, 1'b0, 1'b0, K_RUNT};
    vecs[6] = '{mk_beat0(MAC_A, 16'hCAFE), 8'h3F, 2, MAC_A, 1'b0, 1'b0, K_ACC};
    vecs[7] = '{mk_beat0(MAC_A, 16'hCAFE), 8'h1F, 1, MAC_A, 1'b1, 1'b1, K_RUNT};
    rdy_mode = 0;
    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].mac, vecs[v].promisc, vecs[v].bcast);
      send_frame(vecs[v].n, vecs[v].b0, vecs[v].k0, vecs[v].kind,
                 (vecs[v].kind == K_ACC) ? F_LAT : F_NOOUT, $sformatf("vec%0d", v));
      wait_drain($sformatf("vec%0d", v));
    end

    // short first beat without tlast: runt, remains in IDLE
    set_cfg(MAC_A, 1'b0, 1'b0);
    send_beat(mk_beat0(MAC_A, 16'h0), 8'h1F, 1'b0, stalls);
    s_tvalid = 1'b0;
    exp_runt = sat_inc(exp_runt);
    check("runt_keep_no_out", m_tvalid, 1'b0);
    check("runt_keep_state", dbg_state, IDLE);
    check_counters("runt_keep");

    // toggling sink ready on a 4-beat matching frame
    rdy_mode = 2;
    chk_ready_rule = 1;
    send_frame(4, mk_beat0(MAC_A, 16'h7777), 8'hFF, K_ACC, 0, "toggle");
    wait_drain("toggle");
    chk_ready_rule = 0;
    rdy_mode = 0;

    // saturation of the accept counter, then clear racing a tlast accept
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    exp_acc = 0;
    exp_drop = 0;
    exp_runt = 0;
    check_counters("clr");
    for (int i = 0; i < CMAX + 2; i++) send_frame(2, mk_beat0(MAC_A, 16'(i)), 8'hFF, K_ACC, 0, "sat");
    wait_drain("sat");
    check("sat_pinned", stat_accept_cnt, 4'hF);
    send_frame(3, mk_beat0(MAC_A, 16'h0001), 8'hFF, K_ACC, F_CLR, "clr_race");
    wait_drain("clr_race");

    // reset in the middle of a forwarded frame
    b = mk_beat0(MAC_A, 16'hAAAA);
    exp_q.push_back({1'b0, 8'hFF, b});
    send_beat(b, 8'hFF, 1'b0, stalls);
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, stalls);
    s_tvalid = 1'b0;
    check("midrst_state_pass", dbg_state, PASS);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_s_tready", s_tready, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_queue", exp_q.size(), 0);
    exp_acc = 0;
    exp_drop = 0;
    exp_runt = 0;
    check_counters("midrst");
    rst_n = 1'b1;
    // the rest of the old frame is parsed afresh: a non-matching first beat
    send_frame(2, mk_beat0(48'h0600_0000_0009, 16'h0), 8'hFF, K_DROP, F_NOOUT, "resync");
    wait_drain("resync");

    // randomized frames against the model, random sink backpressure
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      set_cfg({16'($urandom), $urandom}, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      case ($urandom_range(0, 3))
        0: d = cfg_mac_addr;
        1: d = 48'hFFFF_FFFF_FFFF;
        2: d = {16'($urandom), $urandom};
        default: d = cfg_mac_addr ^ (48'hFF << (8 * $urandom_range(0, 5)));
      endcase
      n = $urandom_range(1, 5);
      case ($urandom_range(0, 5))
        0: k = 8'($urandom);
        1: k = 8'h3F;
        default: k = 8'hFF;
      endcase
      if (k[5:0] != 6'h3F) n = 1;
      b = mk_beat0(d, 16'($urandom));
      kind = classify(n, b, k, cfg_mac_addr, cfg_promisc, cfg_bcast_en);
      send_frame(n, b, k, kind, F_GAPS | F_SCRAMBLE, "rand");
    end
    wait_drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
